// File: rtl/rc_pwm_channel_decoder.sv
// RC receiver PWM channel decoder: measures pulse high time in us and maps it to 0..250.
// Optional macro RX_GLITCH_FILTER_EN adds a 3-sample stability filter on the synced line.
`ifndef REC_VAL_BIT_WIDTH
`define REC_VAL_BIT_WIDTH 9
`endif

module rc_pwm_channel_decoder #(
   parameter int MIN_PULSE_US   = 1000,
   parameter int MIN_VALID_US   = 800,
   parameter int MAX_VALID_US   = 2500,
   parameter int TIMEOUT_US     = 30000,
   parameter int FAILSAFE_VALUE = 0
) (
   input  logic                          us_clk,
   input  logic                          resetn,
   input  logic                          pwm_in,
   output logic [`REC_VAL_BIT_WIDTH-1:0] pwm_value_out,
   output logic                          complete_signal,
   output logic                          active_signal,
   output logic                          signal_lost
);

   localparam int VW = `REC_VAL_BIT_WIDTH;
   localparam logic [15:0] MIN_PULSE16 = 16'(MIN_PULSE_US);
   localparam logic [15:0] MIN_VALID16 = 16'(MIN_VALID_US);
   localparam logic [15:0] MAX_VALID16 = 16'(MAX_VALID_US);
   localparam logic [15:0] TO_MAX16    = 16'(TIMEOUT_US);
   localparam logic [VW-1:0] FAILSAFE  = VW'(FAILSAFE_VALUE);

   typedef enum logic [2:0] {WAIT_LOW, WAIT_RISE, MEASURE, CONVERT, DONE} state_t;

   state_t      state, state_nxt;
   logic        sync_p0, sync_p1, lvl, lvl_p2, rise_p2, fall_p2;
   logic [15:0] width_cnt, timeout_cnt;
   logic        start_meas, count_en, load_out, fire_to;

   function automatic logic [VW-1:0] map_width(input logic [15:0] w);
      logic [15:0] d;
      if (w <= MIN_PULSE16) return '0;
      d = (w - MIN_PULSE16) >> 2;
      if (d > 16'd250) d = 16'd250;
      return d[VW-1:0];
   endfunction

   // Stage p0/p1: synchronizer, idles high so a line held high through reset is not seen as a rise
   always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
      end else begin
         sync_p0 <= pwm_in;
         sync_p1 <= sync_p0;
      end
   end

`ifdef RX_GLITCH_FILTER_EN
   logic hist_a, hist_b, filt_q;

   always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
         hist_a <= 1'b1;
         hist_b <= 1'b1;
         filt_q <= 1'b1;
      end else begin
         hist_a <= sync_p1;
         hist_b <= hist_a;
         filt_q <= lvl;
      end
   end

   always_comb lvl = (sync_p1 == hist_a && hist_a == hist_b) ? sync_p1 : filt_q;
`else
   always_comb lvl = sync_p1;
`endif

   // Stage p2: registered edge detector
   always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
         lvl_p2  <= 1'b1;
         rise_p2 <= 1'b0;
         fall_p2 <= 1'b0;
      end else begin
         lvl_p2  <= lvl;
         rise_p2 <= lvl & ~lvl_p2;
         fall_p2 <= ~lvl & lvl_p2;
      end
   end

   always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) state <= WAIT_LOW;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_LOW:  if (!lvl_p2) state_nxt = WAIT_RISE;
         WAIT_RISE: if (rise_p2) state_nxt = MEASURE;
         MEASURE: begin
            if (width_cnt > MAX_VALID16) state_nxt = WAIT_LOW;
            else if (fall_p2) state_nxt = (width_cnt < MIN_VALID16) ? WAIT_RISE : CONVERT;
         end
         CONVERT:   state_nxt = DONE;
         DONE:      state_nxt = WAIT_RISE;
         default:   state_nxt = WAIT_LOW;
      endcase
   end

   always_comb begin
      active_signal = 1'b0;
      start_meas    = 1'b0;
      count_en      = 1'b0;
      load_out      = 1'b0;
      case (state)
         WAIT_RISE: start_meas = rise_p2;
         MEASURE: begin
            active_signal = 1'b1;
            count_en      = lvl_p2;
         end
         CONVERT:   load_out = 1'b1;
         default:   ;
      endcase
      // A decoded pulse landing on the same edge as the timeout takes priority
      fire_to = !load_out && !signal_lost && (timeout_cnt == TO_MAX16 - 16'd1);
   end

   // Output registers update on the edge entering DONE, so the strobe and new value appear together
   always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
         width_cnt       <= '0;
         timeout_cnt     <= '0;
         pwm_value_out   <= FAILSAFE;
         complete_signal <= 1'b0;
         signal_lost     <= 1'b1;
      end else begin
         complete_signal <= load_out | fire_to;
         if (load_out) begin
            pwm_value_out <= map_width(width_cnt);
            signal_lost   <= 1'b0;
            timeout_cnt   <= '0;
         end else begin
            if (timeout_cnt != TO_MAX16) timeout_cnt <= timeout_cnt + 16'd1;
            if (fire_to) begin
               signal_lost   <= 1'b1;
               pwm_value_out <= FAILSAFE;
            end
         end
         if (start_meas) width_cnt <= 16'd1;
         else if (count_en && width_cnt != 16'hFFFF) width_cnt <= width_cnt + 16'd1;
      end
   end

endmodule

// File: doc/rc_pwm_channel_decoder.md
Name: rc_pwm_channel_decoder

Overview:
- Upstream stage of throttle_change_limiter.
- Measures the high time of one RC receiver PWM channel in microseconds on us_clk and maps it to an unsigned command value of 0..250.
- On each accepted pulse, presents the value with a one-cycle strobe that drives the limiter's start_signal / throttle_pwm_value_in.
- Rejects out-of-range pulses and forces a failsafe value when the receiver goes silent.

Parameters:
- MIN_PULSE_US, 1000: pulse width that maps to 0.
- MIN_VALID_US, 800: pulses shorter than this are discarded.
- MAX_VALID_US, 2500: pulses longer than this are discarded.
- TIMEOUT_US, 30000: time without an accepted pulse before signal loss.
- FAILSAFE_VALUE, 0: output value forced on signal loss.

Ports:
- us_clk  input  1  1 MHz clock, only clock.
- resetn  input  1  asynchronous active-low reset.
- pwm_in  input  1  raw receiver PWM line, asynchronous to us_clk.
- pwm_value_out  output  `REC_VAL_BIT_WIDTH  decoded value 0..250, zero-extended, sign bit always 0.
- complete_signal  output  1  one-cycle strobe when pwm_value_out updates.
- active_signal  output  1  high while a pulse is being measured.
- signal_lost  output  1  high while in timeout/failsafe.

Behaviour:
- Reset values: pwm_value_out=FAILSAFE_VALUE, complete_signal=0, active_signal=0, signal_lost=1, FSM=WAIT_LOW, counters=0.
- Input path: pwm_in passes through a 2-FF synchronizer, then a registered edge detector. Rise/fall are seen 3 us_clk after the pin edge.
- FSM states:
  - WAIT_LOW: arm only once the synced line is low, so no partial pulse is measured after reset. Then go to WAIT_RISE.
  - WAIT_RISE: on a detected rise, set width_cnt=1, active_signal=1, go to MEASURE.
  - MEASURE: width_cnt+1 each cycle the synced line stays high. width_cnt is 16-bit and saturating.
    - If width_cnt > MAX_VALID_US: abort to WAIT_LOW, active_signal=0, no output.
    - On a detected fall: active_signal=0.
      - width < MIN_VALID_US: discard, go to WAIT_RISE.
      - Otherwise go to CONVERT.
  - CONVERT: register the mapped value, go to DONE.
  - DONE: drive pwm_value_out, pulse complete_signal for exactly 1 cycle, clear signal_lost and timeout_cnt, go to WAIT_RISE.
- Width definition: number of us_clk cycles the synced line was sampled high.
- Mapping:
  - width <= MIN_PULSE_US -> 0.
  - Otherwise (width - MIN_PULSE_US) >> 2, clamped to 250.
  - Unsigned arithmetic, 16-bit intermediate.
- Latency: complete_signal asserts 2 us_clk after the cycle the fall is detected.
- Timeout:
  - timeout_cnt (16-bit) increments every cycle and clears only in DONE.
  - On reaching TIMEOUT_US while signal_lost=0: set signal_lost=1, pwm_value_out=FAILSAFE_VALUE, one complete_signal pulse.
  - The counter then holds at TIMEOUT_US; no repeated strobes.
- Simultaneous events: DONE and timeout in the same cycle -> DONE wins.
- Reset mid-pulse: all state returns to reset values immediately; the next measurement requires a low, then a rise.

Optional Feature:
- Macro: RX_GLITCH_FILTER_EN.
- Defined: the synced line passes through a 3-sample majority/stability filter. The filtered level changes only after 3 consecutive equal samples, so edge detection latency is +2 cycles. High pulses of 2 us or less are ignored entirely. The measured width is unchanged for clean pulses, because both edges are delayed equally.
- Undefined: no filter; edges are taken directly from the synchronizer.

Test Plan:
- Reset with pwm_in held high, then release for a 1500 us pulse: first partial pulse ignored, no strobe. Next low->1500 us pulse -> pwm_value_out=125, one complete_signal, signal_lost=0.
- Pulses of 1000, 1400, 2000 and 2200 us -> outputs 0, 100, 250, 250 (clamped), each with exactly one strobe 2 cycles after fall detect.
- Pulses of 500 us and 3000 us -> no strobe, output holds the previous value, FSM re-arms; a following 1600 us pulse -> 150.
- Valid 1800 us pulse (-> 200), then pwm_in held low for 30000 us -> signal_lost=1, pwm_value_out=0, single strobe. Next 1800 us pulse -> 200, signal_lost=0.
- Assert resetn low mid-MEASURE -> outputs at reset values, active_signal=0. The subsequent full pulse decodes correctly.
- With RX_GLITCH_FILTER_EN: 1 us and 2 us high spikes -> no measurement, active_signal stays 0. A 1500 us pulse -> 125.
